id_stage: RTL and testbench

Parametrised, pipelined instruction-decode stage for the MIPS32 core. Sits between the fetch stage and execute: it holds the architectural register file, reads rs/rt, sign- or zero-extends the immediate, and registers A/B/Imm/NPC/IR into the ID/EX pipeline register under a valid/ready handshake. Adds write-back bypass, load-use stall detection and flush, none of which the previous combinational decoder had.

---
 rtl/id_pkg.sv | 58 +++++
 rtl/id_regfile.sv | 43 ++++
 rtl/id_stage.sv | 117 +++++++++++
 tb/tb_id_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared definitions for the MIPS32 instruction-decode stage: opcodes,
// instruction field positions and small field-extraction helpers.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int OPC_LO = 26;
    localparam int RS_LO  = 21;
    localparam int RT_LO  = 16;
    localparam int RD_LO  = 11;
    localparam int IMM_LO = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        IMM_SIGN,
        IMM_ZERO,
        IMM_UPPER
    } imm_kind_e;

    function automatic logic [5:0] opcode_of(input logic [31:0] ir);
        return ir[OPC_LO +: 6];
    endfunction

    function automatic logic [4:0] rs_of(input logic [31:0] ir);
        return ir[RS_LO +: 5];
    endfunction

    function automatic logic [4:0] rt_of(input logic [31:0] ir);
        return ir[RT_LO +: 5];
    endfunction

    function automatic logic [15:0] imm16_of(input logic [31:0] ir);
        return ir[IMM_LO +: 16];
    endfunction

    // Opcodes whose rt field is a source operand rather than a destination.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

    function automatic imm_kind_e imm_kind(input logic [5:0] op);
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: return IMM_ZERO;
            OP_LUI:                   return IMM_UPPER;
            default:                  return IMM_SIGN;
        endcase
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: two combinational read ports with write-back
// bypass, one write port, register 0 hard-wired to zero, async clear.
module id_regfile
    import id_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      ra_addr_i,
    input  logic [4:0]      rb_addr_i,
    output logic [XLEN-1:0] ra_data_o,
    output logic [XLEN-1:0] rb_data_o,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    localparam int IW = $clog2(NREG);

    logic [XLEN-1:0] regs_q [NREG];
    logic [IW-1:0]   wi, ai, bi;
    logic            wr_ok;

    assign wi    = waddr_i[IW-1:0];
    assign ai    = ra_addr_i[IW-1:0];
    assign bi    = rb_addr_i[IW-1:0];
    assign wr_ok = we_i && (wi != '0);

    // Entry 0 is never written, so it reads zero without a special read path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (wr_ok) begin
            regs_q[wi] <= wdata_i;
        end
    end

    assign ra_data_o = (wr_ok && (wi == ai)) ? wdata_i : regs_q[ai];
    assign rb_data_o = (wr_ok && (wi == bi)) ? wdata_i : regs_q[bi];

endmodule

// File: rtl/id_stage.sv
// MIPS32 decode stage: register read, immediate extension and the ID/EX
// register under valid/ready. Load-use stall enabled by ID_LOAD_STALL_EN.
module id_stage
    import id_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] npc_if,
    input  logic [31:0]     ir_if,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] npc_id,
    output logic [31:0]     ir_id
);

    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, npc_q, npc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] rf_a, rf_b;
    logic            hazard, adv, accept;

    function automatic logic [XLEN-1:0] ext_imm(input logic [5:0] op, input logic [15:0] i16);
        logic [XLEN+15:0] wide;
        case (imm_kind(op))
            IMM_ZERO:  wide = {{XLEN{1'b0}}, i16};
            IMM_UPPER: wide = {{XLEN{1'b0}}, i16} << 16;
            default:   wide = {{XLEN{i16[15]}}, i16};
        endcase
        return wide[XLEN-1:0];
    endfunction

    id_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .ra_addr_i(rs_of(ir_if)),
        .rb_addr_i(rt_of(ir_if)),
        .ra_data_o(rf_a),
        .rb_data_o(rf_b),
        .we_i     (wb_en),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data)
    );

`ifdef ID_LOAD_STALL_EN
    // A load still in ID/EX cannot feed the instruction behind it this cycle.
    assign hazard = if_valid && id_valid_q && (opcode_of(ir_q) == OP_LW)
                    && (rt_of(ir_q) != 5'd0)
                    && ((rt_of(ir_q) == rs_of(ir_if))
                        || (uses_rt(opcode_of(ir_if)) && (rt_of(ir_q) == rt_of(ir_if))));
`else
    assign hazard = 1'b0;
`endif

    assign adv      = !id_valid_q || ex_ready;
    assign accept   = adv && if_valid && !hazard;
    assign if_ready = adv && !hazard && !rst;

    always_comb begin
        id_valid_d = id_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        imm_d      = imm_q;
        npc_d      = npc_q;
        ir_d       = ir_q;
        if (flush) begin
            id_valid_d = 1'b0;
            ir_d       = NOP;
        end else if (accept) begin
            id_valid_d = 1'b1;
            a_d        = rf_a;
            b_d        = rf_b;
            imm_d      = ext_imm(opcode_of(ir_if), imm16_of(ir_if));
            npc_d      = npc_if;
            ir_d       = ir_if;
        end else if (adv) begin
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            npc_q      <= '0;
            ir_q       <= NOP;
        end else begin
            id_valid_q <= id_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            imm_q      <= imm_d;
            npc_q      <= npc_d;
            ir_q       <= ir_d;
        end
    end

    assign id_valid = id_valid_q;
    assign a        = a_q;
    assign b        = b_q;
    assign imm      = imm_q;
    assign npc_id   = npc_q;
    assign ir_id    = ir_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed vector table, hand-written
// load-use / hold / flush sequences, and randomized traffic against a model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [31:0] npc_if = '0;
    logic [31:0] ir_if = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b1;
    logic        id_valid;
    logic [31:0] a, b, imm, npc_id, ir_id;

    id_stage #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
        .npc_if(npc_if), .ir_if(ir_if), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .flush(flush), .ex_ready(ex_ready),
        .id_valid(id_valid), .a(a), .b(b), .imm(imm), .npc_id(npc_id), .ir_id(ir_id)
    );

    always #5 clk = ~clk;

`ifdef ID_LOAD_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [31:0] m_a, m_b, m_imm, m_npc, m_ir;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic int fop(input logic [31:0] ir); return int'(ir >> 26); endfunction
    function automatic int frs(input logic [31:0] ir); return int'((ir >> 21) & 32'h1F); endfunction
    function automatic int frt(input logic [31:0] ir); return int'((ir >> 16) & 32'h1F); endfunction

    function automatic logic [31:0] model_imm(input logic [31:0] ir);
        logic [15:0] lo;
        lo = ir[15:0];
        case (fop(ir))
            'h0C, 'h0D, 'h0E: return {16'h0000, lo};
            'h0F:             return {lo, 16'h0000};
            default:          return {{16{lo[15]}}, lo};
        endcase
    endfunction

    function automatic logic [31:0] model_read(input int r);
        if (r == 0) return 32'h0;
        if (wb_en && int'(wb_addr) == r) return wb_data;
        return m_regs[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_valid = 1'b0;
        m_a = '0; m_b = '0; m_imm = '0; m_npc = '0; m_ir = '0;
    endtask

    // Advances one clock with current inputs; checks if_ready before the edge
    // and every registered output after it.
    task automatic step(input string tag, output logic rdy_seen);
        logic hz, adv, exp_rdy;
        int   o;
        #2;
        o  = fop(ir_if);
        hz = STALL && if_valid && m_valid && fop(m_ir) == 'h23 && frt(m_ir) != 0
             && (frt(m_ir) == frs(ir_if)
                 || ((o == 'h00 || o == 'h04 || o == 'h05 || o == 'h2B) && frt(m_ir) == frt(ir_if)));
        adv     = !m_valid || ex_ready;
        exp_rdy = adv && !hz;
        rdy_seen = if_ready;
        chk({tag, ".if_ready"}, {31'b0, if_ready}, {31'b0, exp_rdy});
        if (flush) begin
            m_valid = 1'b0;
            m_ir    = '0;
        end else if (adv && if_valid && !hz) begin
            m_valid = 1'b1;
            m_a     = model_read(frs(ir_if));
            m_b     = model_read(frt(ir_if));
            m_imm   = model_imm(ir_if);
            m_npc   = npc_if;
            m_ir    = ir_if;
        end else if (adv) begin
            m_valid = 1'b0;
        end
        if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
        @(posedge clk);
        #1;
        chk({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, m_valid});
        chk({tag, ".a"}, a, m_a);
        chk({tag, ".b"}, b, m_b);
        chk({tag, ".imm"}, imm, m_imm);
        chk({tag, ".npc"}, npc_id, m_npc);
        chk({tag, ".ir"}, ir_id, m_ir);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #2;
        chk({tag, ".if_ready"}, {31'b0, if_ready}, 32'h0);
        @(posedge clk);
        #1;
        model_reset();
        chk({tag, ".id_valid"}, {31'b0, id_valid}, 32'h0);
        chk({tag, ".a"}, a, 32'h0);
        chk({tag, ".b"}, b, 32'h0);
        chk({tag, ".imm"}, imm, 32'h0);
        chk({tag, ".npc"}, npc_id, 32'h0);
        chk({tag, ".ir"}, ir_id, 32'h0);
        rst = 1'b0;
        wb_en = 1'b0;
        if_valid = 1'b0;
        flush = 1'b0;
        ex_ready = 1'b1;
    endtask

    typedef struct {
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic [31:0] ir;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] eimm;
    } vec_t;

    vec_t vt [7];

    initial begin
        logic r;
        int   op_tab [10];

        vt[0] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0, 32'h0, 32'h0};
        vt[1] = '{1'b1, 5'd1, 32'hAAAA_BBBB, 32'h0000_0000, 32'h0, 32'h0, 32'h0};
        vt[2] = '{1'b0, 5'd0, 32'h0, 32'h0021_0800, 32'hAAAA_BBBB, 32'hAAAA_BBBB, 32'h0000_0800};
        vt[3] = '{1'b1, 5'd3, 32'h1111_2222, 32'h0060_0000, 32'h1111_2222, 32'h0, 32'h0};
        vt[4] = '{1'b0, 5'd0, 32'h0, 32'h2021_8000, 32'hAAAA_BBBB, 32'hAAAA_BBBB, 32'hFFFF_8000};
        vt[5] = '{1'b0, 5'd0, 32'h0, 32'h3421_8000, 32'hAAAA_BBBB, 32'hAAAA_BBBB, 32'h0000_8000};
        vt[6] = '{1'b0, 5'd0, 32'h0, 32'h3C01_1234, 32'h0, 32'hAAAA_BBBB, 32'h1234_0000};

        model_reset();
        @(posedge clk);
        #1;
        do_reset("rst0");

        for (int i = 0; i < 7; i++) begin
            if_valid = 1'b1;
            ex_ready = 1'b1;
            wb_en    = vt[i].wb_en;
            wb_addr  = vt[i].wb_addr;
            wb_data  = vt[i].wb_data;
            ir_if    = vt[i].ir;
            npc_if   = 32'h0000_0100 + 32'(i) * 4;
            step($sformatf("vec%0d", i), r);
            chk($sformatf("vec%0d.tab_valid", i), {31'b0, id_valid}, 32'h1);
            chk($sformatf("vec%0d.tab_a", i), a, vt[i].ea);
            chk($sformatf("vec%0d.tab_b", i), b, vt[i].eb);
            chk($sformatf("vec%0d.tab_imm", i), imm, vt[i].eimm);
        end
        wb_en = 1'b0;

        // Load followed by a dependent ADD.
        ir_if = 32'h8C22_0000; npc_if = 32'h200;
        step("lu1", r);
        chk("lu1.v", {31'b0, id_valid}, 32'h1);
        ir_if = 32'h0041_1820; npc_if = 32'h204;
        step("lu2", r);
        chk("lu2.rdy", {31'b0, r}, STALL ? 32'h0 : 32'h1);
        chk("lu2.v", {31'b0, id_valid}, STALL ? 32'h0 : 32'h1);
        step("lu3", r);
        chk("lu3.v", {31'b0, id_valid}, 32'h1);
        chk("lu3.ir", ir_id, 32'h0041_1820);

        // Execute stalls for three cycles, then a flush clears ID/EX.
        ir_if = 32'h38A5_F0F0; npc_if = 32'h300;
        step("hold0", r);
        ex_ready = 1'b0;
        ir_if = 32'h0000_0000; npc_if = 32'h304;
        for (int k = 0; k < 3; k++) begin
            step($sformatf("hold%0d", k + 1), r);
            chk($sformatf("hold%0d.rdy", k + 1), {31'b0, r}, 32'h0);
            chk($sformatf("hold%0d.ir", k + 1), ir_id, 32'h38A5_F0F0);
            chk($sformatf("hold%0d.v", k + 1), {31'b0, id_valid}, 32'h1);
        end
        flush = 1'b1;
        step("flush", r);
        chk("flush.v", {31'b0, id_valid}, 32'h0);
        chk("flush.ir", ir_id, 32'h0);
        flush = 1'b0;
        ex_ready = 1'b1;

        op_tab = '{'h00, 'h04, 'h05, 'h23, 'h2B, 'h08, 'h0C, 'h0D, 'h0E, 'h0F};
        for (int it = 0; it < 400; it++) begin
            if (it == 200) begin
                wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
                do_reset("rstmid");
            end
            if_valid = ($urandom_range(3) != 0);
            ex_ready = ($urandom_range(9) < 7);
            flush    = ($urandom_range(19) == 0);
            wb_en    = $urandom_range(1) == 1;
            wb_addr  = 5'($urandom_range(7));
            wb_data  = $urandom;
            ir_if    = {6'(op_tab[$urandom_range(9)]), 5'($urandom_range(7)),
                        5'($urandom_range(7)), 16'($urandom)};
            npc_if   = $urandom;
            step($sformatf("rnd%0d", it), r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
